// File: rtl/isp_line_buffer.sv
// Line buffer for ISP windowed filters: stores NUM_LINES-1 previous lines and
// emits one column of NUM_LINES vertically aligned pixels per accepted input pixel.
module isp_line_buffer #(
  parameter int DATA_WIDTH = 40,
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_LINES  = 4
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  s_valid_i,
  output logic                                  s_ready_o,
  input  logic [DATA_WIDTH-1:0]                 s_data_i,
  input  logic                                  s_frame_start_i,
  input  logic                                  s_line_end_i,
  output logic                                  m_valid_o,
  input  logic                                  m_ready_i,
  output logic [NUM_LINES-1:0][DATA_WIDTH-1:0]  m_data_o,
  output logic [NUM_LINES-1:0]                  m_rows_valid_o,
  output logic                                  m_line_end_o,
  output logic                                  overflow_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BW    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam logic [ADDR_WIDTH-1:0] COL_MAX   = '1;
  localparam logic [BW-1:0]         LAST_BANK = BW'(NUM_LINES - 1);

  logic [ADDR_WIDTH-1:0] col_q, col_p0, col_nxt;
  logic [BW-1:0]         wr_bank_q, wr_bank_nxt;
  logic [BW-1:0]         filled_q, filled_p0, filled_nxt;
  logic                  ovf_q, ovf_p0, ovf_nxt;
  logic                  acc_p0;
  logic [NUM_LINES-1:0]  rows_p0;

  logic                                 vld_p1;
  logic [DATA_WIDTH-1:0]                pix_p1;
  logic [BW-1:0]                        bank_p1;
  logic [NUM_LINES-1:0]                 rows_p1;
  logic                                 le_p1;
  logic [NUM_LINES-1:0][DATA_WIDTH-1:0] rd_p1;

  assign s_ready_o = !vld_p1 || m_ready_i;
  assign acc_p0    = s_valid_i && s_ready_o;

  // p0: frame start rewinds position before the line-end/overflow update
  always_comb begin
    col_p0    = s_frame_start_i ? '0 : col_q;
    filled_p0 = s_frame_start_i ? '0 : filled_q;
    ovf_p0    = s_frame_start_i ? 1'b0 : ovf_q;
    col_nxt     = col_p0;
    wr_bank_nxt = wr_bank_q;
    filled_nxt  = filled_p0;
    ovf_nxt     = ovf_p0;
    if (s_line_end_i) begin
      col_nxt     = '0;
      wr_bank_nxt = (wr_bank_q == LAST_BANK) ? '0 : wr_bank_q + BW'(1);
      filled_nxt  = (filled_p0 == LAST_BANK) ? filled_p0 : filled_p0 + BW'(1);
    end else if (col_p0 == COL_MAX) begin
      ovf_nxt = 1'b1;
    end else begin
      col_nxt = col_p0 + ADDR_WIDTH'(1);
    end
    for (int k = 0; k < NUM_LINES; k++) begin
      rows_p0[k] = (k <= int'(filled_p0));
    end
  end

  // Each bank either takes the new pixel or returns its stored pixel at the same column
  for (genvar b = 0; b < NUM_LINES; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    always_ff @(posedge clk_i) begin
      if (acc_p0) begin
        if (wr_bank_q == BW'(b)) mem[col_p0] <= s_data_i;
        else                     rd_q        <= mem[col_p0];
      end
    end
    assign rd_p1[b] = rd_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      col_q     <= '0;
      wr_bank_q <= '0;
      filled_q  <= '0;
      ovf_q     <= 1'b0;
      vld_p1    <= 1'b0;
      bank_p1   <= '0;
      rows_p1   <= '0;
      le_p1     <= 1'b0;
    end else if (acc_p0) begin
      col_q     <= col_nxt;
      wr_bank_q <= wr_bank_nxt;
      filled_q  <= filled_nxt;
      ovf_q     <= ovf_nxt;
      vld_p1    <= 1'b1;
      bank_p1   <= wr_bank_q;
      rows_p1   <= rows_p0;
      le_p1     <= s_line_end_i;
    end else if (m_ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc_p0) pix_p1 <= s_data_i;
  end

  // p1: route bank read data to window rows relative to the bank written by this column
  always_comb begin
    logic [BW-1:0] idx;
    m_data_o = '0;
    idx      = '0;
    if (vld_p1) begin
      m_data_o[0] = pix_p1;
      for (int k = 1; k < NUM_LINES; k++) begin
        idx         = BW'((int'(bank_p1) + NUM_LINES - k) % NUM_LINES);
        m_data_o[k] = rd_p1[idx];
      end
    end
  end

  assign m_valid_o      = vld_p1;
  assign m_rows_valid_o = rows_p1;
  assign m_line_end_o   = le_p1;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_isp_line_buffer.sv
// Bench for isp_line_buffer (4 lines, 8-pixel lines, 8-bit pixels): directed
// scenarios with literal expectations plus randomized traffic against a line-store model.
module tb_isp_line_buffer;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NL = 4;
  localparam int LEN = 8;

  logic              clk_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic              s_valid_i = 1'b0;
  logic              s_ready_o;
  logic [DW-1:0]     s_data_i = '0;
  logic              s_frame_start_i = 1'b0;
  logic              s_line_end_i = 1'b0;
  logic              m_valid_o;
  logic              m_ready_i = 1'b1;
  logic [NL-1:0][DW-1:0] m_data_o;
  logic [NL-1:0]     m_rows_valid_o;
  logic              m_line_end_o;
  logic              overflow_o;

  isp_line_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LINES(NL)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .s_frame_start_i(s_frame_start_i), .s_line_end_i(s_line_end_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_rows_valid_o(m_rows_valid_o), .m_line_end_o(m_line_end_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready: random when rr_en, otherwise ready_force
  logic rr_en = 1'b0;
  logic ready_force = 1'b1;
  always @(posedge clk_i) begin
    #1;
    m_ready_i = rr_en ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Reference model: the line store as a plain 2-D array plus position bookkeeping
  logic [DW-1:0] mem_m   [NL][LEN];
  bit            known_m [NL][LEN];
  int            mcol = 0, mwrb = 0, mlf = 0;
  bit            movf = 0;
  bit            exp_vld = 0, exp_le = 0;
  logic [DW-1:0] exp_data [NL];
  bit            exp_known [NL];
  bit [NL-1:0]   exp_rows = '0;

  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      chk("rst_valid", 32'(m_valid_o), 32'd0);
      chk("rst_data", 32'(m_data_o), 32'd0);
      chk("rst_rows", 32'(m_rows_valid_o), 32'd0);
      chk("rst_le", 32'(m_line_end_o), 32'd0);
      chk("rst_ovf", 32'(overflow_o), 32'd0);
      chk("rst_ready", 32'(s_ready_o), 32'd1);
      mcol = 0; mwrb = 0; mlf = 0; movf = 0; exp_vld = 0;
    end else begin
      chk("valid", 32'(m_valid_o), 32'(exp_vld));
      chk("s_ready", 32'(s_ready_o), 32'(!exp_vld || m_ready_i));
      chk("overflow", 32'(overflow_o), 32'(movf));
      if (exp_vld) begin
        chk("rows", 32'(m_rows_valid_o), 32'(exp_rows));
        chk("line_end", 32'(m_line_end_o), 32'(exp_le));
        for (int k = 0; k < NL; k++)
          if (exp_rows[k] && exp_known[k]) chk($sformatf("data%0d", k), 32'(m_data_o[k]), 32'(exp_data[k]));
      end
      if (s_valid_i && (!exp_vld || m_ready_i)) begin
        int c;
        if (s_frame_start_i) begin mcol = 0; mlf = 0; movf = 0; end
        c = mcol;
        exp_data[0] = s_data_i; exp_known[0] = 1;
        for (int k = 1; k < NL; k++) begin
          exp_data[k]  = mem_m[(mwrb - k + NL) % NL][c];
          exp_known[k] = known_m[(mwrb - k + NL) % NL][c];
        end
        for (int k = 0; k < NL; k++) exp_rows[k] = (k <= mlf);
        exp_le = s_line_end_i; exp_vld = 1;
        mem_m[mwrb][c] = s_data_i; known_m[mwrb][c] = 1;
        if (s_line_end_i) begin
          mcol = 0; mwrb = (mwrb + 1) % NL; mlf = (mlf < NL - 1) ? mlf + 1 : NL - 1;
        end else if (c == LEN - 1) begin
          movf = 1;
        end else begin
          mcol = c + 1;
        end
      end else if (m_ready_i) begin
        exp_vld = 0;
      end
    end
  end

  // Offer one pixel and return 1 time unit after the edge that accepted it
  task automatic send_px(input logic [DW-1:0] d, input logic fs, input logic le);
    bit done = 0;
    s_valid_i = 1; s_data_i = d; s_frame_start_i = fs; s_line_end_i = le;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (s_ready_o) done = 1;
      @(posedge clk_i); #1;
    end
    s_valid_i = 0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: pixel %0h never accepted", d);
    end
  endtask

  task automatic idle(input int n);
    s_valid_i = 0;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  initial begin
    for (int b = 0; b < NL; b++) for (int c = 0; c < LEN; c++) known_m[b][c] = 0;
    repeat (3) @(posedge clk_i);
    #3 reset_n_i = 1;
    @(posedge clk_i); #1;
    chk("post_reset_valid", 32'(m_valid_o), 32'd0);
    chk("post_reset_ready", 32'(s_ready_o), 32'd1);

    // Full frame 4 x 8, pixel = 16*line + col
    for (int l = 0; l < 4; l++)
      for (int c = 0; c < LEN; c++) begin
        send_px(DW'(16 * l + c), l == 0 && c == 0, c == LEN - 1);
        if (l == 3 && c == 5) begin
          chk("l3c5_valid", 32'(m_valid_o), 32'd1);
          chk("l3c5_data", 32'(m_data_o), 32'h05152535);
          chk("l3c5_rows", 32'(m_rows_valid_o), 32'hF);
        end
      end

    // New frame of 5 lines; the 5th line reuses bank 0
    for (int l = 0; l < 5; l++)
      for (int c = 0; c < LEN; c++) begin
        send_px(DW'(16 * l + c), l == 0 && c == 0, c == LEN - 1);
        if (l == 1 && c == 2) begin
          chk("l1c2_d0", 32'(m_data_o[0]), 32'h12);
          chk("l1c2_d1", 32'(m_data_o[1]), 32'h02);
          chk("l1c2_rows", 32'(m_rows_valid_o), 32'b0011);
        end
        if (l == 4 && c == 2) begin
          chk("l4c2_d0", 32'(m_data_o[0]), 32'h42);
          chk("l4c2_d3", 32'(m_data_o[3]), 32'h12);
          chk("l4c2_rows", 32'(m_rows_valid_o), 32'hF);
        end
      end
    idle(3);

    // Downstream stall for 5 cycles with a pixel waiting
    ready_force = 0;
    idle(2);
    send_px(8'h55, 1'b1, 1'b0);
    s_valid_i = 1; s_data_i = 8'h66; s_frame_start_i = 0; s_line_end_i = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("stall_ready", 32'(s_ready_o), 32'd0);
      chk("stall_data", 32'(m_data_o[0]), 32'h55);
      @(posedge clk_i); #1;
    end
    ready_force = 1;
    send_px(8'h66, 1'b0, 1'b1);
    chk("release_data", 32'(m_data_o[0]), 32'h66);
    idle(3);

    // Overflow: 9 pixels without line end, then frame start clears it
    for (int i = 0; i < 9; i++) begin
      send_px(DW'(8'h80 + i), i == 0, 1'b0);
      if (i == 6) chk("ovf_before", 32'(overflow_o), 32'd0);
      if (i == 7) chk("ovf_set", 32'(overflow_o), 32'd1);
    end
    send_px(8'h8F, 1'b0, 1'b1);
    chk("ovf_sticky", 32'(overflow_o), 32'd1);
    send_px(8'h90, 1'b1, 1'b0);
    chk("ovf_cleared", 32'(overflow_o), 32'd0);
    send_px(8'h91, 1'b0, 1'b1);
    idle(2);

    // Asynchronous reset in the middle of line 2
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < LEN && !(l == 2 && c > 3); c++)
        send_px(DW'(16 * l + c), l == 0 && c == 0, c == LEN - 1);
    #2 reset_n_i = 0;
    #1;
    chk("async_valid", 32'(m_valid_o), 32'd0);
    chk("async_data", 32'(m_data_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #3 reset_n_i = 1;
    @(posedge clk_i); #1;
    for (int c = 0; c < LEN; c++) begin
      send_px(DW'(8'hC0 + c), c == 0, c == LEN - 1);
      chk("after_rst_rows", 32'(m_rows_valid_o), 32'b0001);
    end
    idle(2);

    // Single-pixel lines
    for (int i = 0; i < 5; i++) begin
      send_px(DW'(8'hA0 + i), i == 0, 1'b1);
      if (i == 1) chk("sp_rows1", 32'(m_rows_valid_o), 32'b0011);
    end
    chk("sp_data", 32'(m_data_o), 32'hA1A2A3A4);
    chk("sp_rows", 32'(m_rows_valid_o), 32'hF);
    idle(2);

    // Randomized traffic with random backpressure
    rr_en = 1;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send_px(DW'($urandom), n == 0 || $urandom_range(0, 99) == 0, $urandom_range(0, 6) == 0);
    end
    rr_en = 0;
    ready_force = 1;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
